// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
// Holds the FSM state encoding, line levels and a width helper.
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and ticks on the last count.
// Shared by the transmitter and the receiver of the serial link.
module serial_bit_timer
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = min1_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // With CLKS_PER_BIT=1 the count stays at 0 and tick is constant while enabled.
    assign tick = enable && (r_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Handshake: a word transfers on a rising edge where load_valid && load_ready; load_ready is high only in IDLE.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             tx_out,
    output logic             tx_active,
    output logic             done,
    output state_t           dbg_state
);

    localparam int BIT_W = min1_clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [BIT_W-1:0]   r_bit_idx;
    logic               r_tx;
    logic               r_done;

    state_t             w_next_state;
    logic [WIDTH-1:0]   w_next_shift;
    logic [BIT_W-1:0]   w_next_bit_idx;
    logic               w_next_tx;
    logic               w_timer_en;
    logic               w_tick;

    assign w_timer_en = (r_state != ST_IDLE);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (w_timer_en),
        .tick   (w_tick)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_bit_idx = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_next_state   = ST_START;
                    w_next_shift   = data_in;
                    w_next_bit_idx = '0;
                end
            end
            ST_START: begin
                if (w_tick) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_next_shift = r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_next_bit_idx = '0;
                        w_next_state   = ST_STOP;
                    end else begin
                        w_next_bit_idx = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        // Line level is registered from the next state so tx_out never glitches.
        case (w_next_state)
            ST_START: w_next_tx = START_LVL;
            ST_DATA:  w_next_tx = w_next_shift[0];
            ST_STOP:  w_next_tx = STOP_LVL;
            default:  w_next_tx = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= LINE_IDLE;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_bit_idx <= w_next_bit_idx;
            r_tx      <= w_next_tx;
            r_done    <= (r_state == ST_STOP) && w_tick;
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign tx_active  = (r_state != ST_IDLE);
    assign tx_out     = r_tx;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: frame-level model with per-cycle compare on an 8-bit/4-clock
// instance, plus literal checks on that instance and on an 8-bit/1-clock instance.
module tb_serial_frame_tx;
    import serial_link_pkg::*;

    localparam int W   = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, load_valid, load_ready, tx_out, tx_active, done;
    logic [W-1:0] data_in;
    state_t       dbg_state;

    logic         b_rst, b_load_valid, b_load_ready, b_tx_out, b_tx_active, b_done;
    logic [W-1:0] b_data_in;
    state_t       b_dbg_state;

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .tx_out(tx_out), .tx_active(tx_active),
        .done(done), .dbg_state(dbg_state)
    );

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(b_rst), .data_in(b_data_in), .load_valid(b_load_valid),
        .load_ready(b_load_ready), .tx_out(b_tx_out), .tx_active(b_tx_active),
        .done(b_done), .dbg_state(b_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of expected {tx_out, tx_active, done, load_ready} for upcoming cycles.
    logic [3:0] exp_q[$];
    logic [3:0] m_cur = 4'b1001;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        logic [3:0] nxt;
        logic       lvl;
        if (rst) begin
            exp_q.delete();
            nxt = 4'b1001;
            m_valid <= 1'b1;
        end else if (m_valid && m_cur[0] && load_valid) begin
            for (int b = 0; b < W + 2; b++) begin
                if (b == 0)      lvl = 1'b0;
                else if (b <= W) lvl = data_in[b-1];
                else             lvl = 1'b1;
                for (int c = 0; c < CPB; c++) exp_q.push_back({lvl, 1'b1, 1'b0, 1'b0});
            end
            exp_q.push_back(4'b1011);
            nxt = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            nxt = exp_q.pop_front();
        end else begin
            nxt = 4'b1001;
        end
        m_cur <= nxt;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tx_out",     {31'd0, tx_out},     {31'd0, m_cur[3]});
            chk("model_tx_active",  {31'd0, tx_active},  {31'd0, m_cur[2]});
            chk("model_done",       {31'd0, done},       {31'd0, m_cur[1]});
            chk("model_load_ready", {31'd0, load_ready}, {31'd0, m_cur[0]});
        end
    end

    task automatic wait_done_a(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic handshake_a(input logic [W-1:0] d);
        @(posedge clk);
        #1 data_in = d;
        load_valid = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [9:0]   lit_a5;
        logic [9:0]   lit_b;
        logic [W-1:0] got;
        int           done_cyc;
        int           pulses;

        lit_a5 = 10'b1101001010;
        lit_b  = 10'b1000000010;
        got    = '0;

        rst = 1'b1; load_valid = 1'b0; data_in = '0;
        b_rst = 1'b1; b_load_valid = 1'b0; b_data_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; b_rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_tx_out", {31'd0, tx_out}, 32'd1);
            chk("idle_active", {31'd0, tx_active}, 32'd0);
            chk("idle_ready",  {31'd0, load_ready}, 32'd1);
            chk("idle_done",   {31'd0, done}, 32'd0);
        end

        // 0xA5, with 0x3C held valid during the frame.
        handshake_a(8'hA5);
        #1 data_in = 8'h3C;
        done_cyc = 0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c <= 40) chk("a5_line", {31'd0, tx_out}, {31'd0, lit_a5[(c-1)/CPB]});
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 41) chk("a5_done_ready", {31'd0, load_ready}, 32'd1);
            if (c == 42) begin
                chk("3c_start_bit", {31'd0, tx_out}, 32'd0);
                chk("3c_active",    {31'd0, tx_active}, 32'd1);
            end
        end
        chk("a5_done_cycle", done_cyc, 32'd41);
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_done_a("3c_done_timeout", 100);
        repeat (3) @(posedge clk);

        // 0xC3 with data_in cleared one cycle after the handshake.
        handshake_a(8'hC3);
        #1 load_valid = 1'b0;
        @(posedge clk);
        #1 data_in = 8'h00;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 5 && c <= 36 && ((c - 5) % CPB) == 2) got[(c-5)/CPB] = tx_out;
        end
        chk("c3_data_bits", {24'd0, got}, 32'h0000_00C3);
        wait_done_a("c3_done_timeout", 100);
        repeat (2) @(posedge clk);

        // 0xFF abandoned by reset during cycle 15.
        handshake_a(8'hFF);
        #1 load_valid = 1'b0;
        for (int c = 1; c <= 14; c++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk("rst_active", {31'd0, tx_active}, 32'd0);
        chk("rst_ready",  {31'd0, load_ready}, 32'd1);
        chk("rst_done",   {31'd0, done}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("rst_no_done", pulses, 32'd0);

        // One clock per bit: 0x01.
        @(posedge clk);
        #1 b_data_in = 8'h01;
        b_load_valid = 1'b1;
        @(posedge clk);
        #1 b_load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                chk("b_line",   {31'd0, b_tx_out}, {31'd0, lit_b[c-1]});
                chk("b_active", {31'd0, b_tx_active}, 32'd1);
                chk("b_done_early", {31'd0, b_done}, 32'd0);
            end else begin
                chk("b_done",       {31'd0, b_done}, 32'd1);
                chk("b_idle_line",  {31'd0, b_tx_out}, 32'd1);
                chk("b_idle_ready", {31'd0, b_load_ready}, 32'd1);
            end
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter: the sending end of the team's single-wire serial link.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts out a frame of start bit, WIDTH data bits (LSB first) and stop bit, each held for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the serial line; pairs with the link's deserialising receiver.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- CLKS_PER_BIT, 4, clocks each serial bit is held (>=1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only at handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word (IDLE only).
- tx_out  output  1  serial line; idles high.
- tx_active  output  1  high while a frame bit (start, data, stop) is on tx_out.
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (rst high at a clk edge, overrides everything): state=IDLE, tx_out=1, tx_active=0, done=0, load_ready=1, shift register and counters cleared.
- Reset mid-frame: the frame is abandoned. On the next cycle tx_out=1 and the word is discarded. No done pulse.
- States and transitions:
  - IDLE -> START on the edge where load_valid && load_ready. data_in is captured into the shift register on that edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after WIDTH*CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0, producing a tick on the last count. A state or bit advance happens only on a tick.
- Bit index: counts 0..WIDTH-1 in DATA and wraps to 0 on the last tick. Width is $clog2(WIDTH) with a minimum of 1. The shift register shifts right one bit per tick.
- tx_out: 0 in START, shift[0] in DATA, 1 in STOP and IDLE. Driven from a register, so the line has no glitches.
- tx_active: 1 in START, DATA and STOP; 0 in IDLE.
- Latency: the first start-bit cycle appears on tx_out in the cycle after the handshake edge. A frame occupies exactly (WIDTH+2)*CLKS_PER_BIT cycles.
- done: 1 for exactly the first IDLE cycle after STOP. load_ready is also 1 in that cycle, so the next handshake can occur in it. Minimum spacing is (WIDTH+2)*CLKS_PER_BIT+1 cycles per frame.
- load_valid while busy: ignored and not queued. The producer holds it until load_ready.
- data_in changes after capture: have no effect on the frame in progress.
- CLKS_PER_BIT=1: the timer is a constant tick, giving one bit per clock.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP (2-bit);
  - line levels LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
- The matching receiver uses the same package.
- One sub-module: serial_bit_timer.
  - Parameter CLKS_PER_BIT; inputs clk, rst, enable; output tick.
  - Counter clears on rst or !enable.
  - Reused by the receiver.

Test Plan:
- Reset, then idle 10 cycles -> tx_out=1, tx_active=0, load_ready=1, done=0 throughout.
- WIDTH=8, CLKS_PER_BIT=4, send 0xA5 -> tx_out sequence 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each held 4 cycles; 40 active cycles; done pulses once at cycle 41.
- Hold load_valid high with 0x3C during the frame for 0xA5 -> 0x3C is not accepted until the done/IDLE cycle; its start bit follows 1 cycle after done.
- Assert rst at cycle 15 of a 0xFF frame -> tx_out=1 and tx_active=0 on the next cycle; no done pulse; load_ready=1.
- CLKS_PER_BIT=1, send 0x01 -> tx_out=0,1,0,0,0,0,0,0,0,1 on consecutive cycles; done at cycle 11.
- Change data_in to 0x00 one cycle after the handshake of 0xC3 -> the serial data bits still encode 0xC3.
